// File: rtl/cpu_mc.sv
// Multi-cycle CPU core: handshake fetch, 3-state execute pipeline, register file and ALU.
// Optional multiply (opcode 0x0B) enabled by defining CPU_MULT_EN.
module cpu_mc #(
    parameter int DATA_W     = 8,
    parameter int REG_ADDR_W = 3,
    parameter int PC_W       = 32
) (
    input  logic            CLK,
    input  logic            RESET,
    output logic            INSTR_REQ,
    output logic [PC_W-1:0] INSTR_ADDR,
    input  logic [31:0]     INSTRUCTION,
    input  logic            INSTR_READY,
    output logic            RETIRE,
    output logic            ILLEGAL,
    output logic [PC_W-1:0] PC
);

    localparam int          NREG = 2 ** REG_ADDR_W;
    localparam logic [31:0] DW_U = 32'(DATA_W);

    localparam logic [7:0] OP_LOADI = 8'h00;
    localparam logic [7:0] OP_MOV   = 8'h01;
    localparam logic [7:0] OP_ADD   = 8'h02;
    localparam logic [7:0] OP_SUB   = 8'h03;
    localparam logic [7:0] OP_AND   = 8'h04;
    localparam logic [7:0] OP_OR    = 8'h05;
    localparam logic [7:0] OP_J     = 8'h06;
    localparam logic [7:0] OP_BEQ   = 8'h07;
    localparam logic [7:0] OP_BNE   = 8'h08;
    localparam logic [7:0] OP_SLL   = 8'h09;
    localparam logic [7:0] OP_SRL   = 8'h0A;
`ifdef CPU_MULT_EN
    localparam logic [7:0] OP_MUL   = 8'h0B;
`endif

    typedef enum logic [1:0] {
        S_RST   = 2'd0,
        S_FETCH = 2'd1,
        S_EXEC  = 2'd2,
        S_WB    = 2'd3
    } state_t;

    state_t              r_state;
    logic [31:0]         r_ir;
    logic [PC_W-1:0]     r_pc;
    logic [PC_W-1:0]     r_next_pc;
    logic [PC_W-1:0]     r_addr;
    logic [DATA_W-1:0]   r_alu;
    logic                r_wen;
    logic                r_req;
    logic                r_retire;
    logic                r_illegal;
    logic [DATA_W-1:0]   r_regs [0:NREG-1];

    logic [7:0]            w_opcode;
    logic [REG_ADDR_W-1:0] w_rd_idx;
    logic [REG_ADDR_W-1:0] w_rs1_idx;
    logic [REG_ADDR_W-1:0] w_rs2_idx;
    logic [DATA_W-1:0]     w_rs1_val;
    logic [DATA_W-1:0]     w_rs2_val;
    logic [DATA_W-1:0]     w_imm;
    logic                  w_shamt_ok;
    logic [PC_W-1:0]       w_offset;
    logic [PC_W-1:0]       w_pc_plus4;
    logic [PC_W-1:0]       w_target;
    logic [DATA_W-1:0]     w_result;
    logic                  w_wen;
    logic                  w_illegal;
    logic                  w_taken;
    logic [PC_W-1:0]       w_next_pc;
    logic                  w_unused;
`ifdef CPU_MULT_EN
    logic [DATA_W-1:0]     w_mul;
`endif

    assign w_opcode   = r_ir[31:24];
    assign w_rd_idx   = r_ir[16 +: REG_ADDR_W];
    assign w_rs1_idx  = r_ir[8 +: REG_ADDR_W];
    assign w_rs2_idx  = r_ir[0 +: REG_ADDR_W];
    assign w_rs1_val  = r_regs[w_rs1_idx];
    assign w_rs2_val  = r_regs[w_rs2_idx];
    assign w_imm      = DATA_W'($signed(r_ir[7:0]));
    assign w_shamt_ok = ({24'd0, r_ir[7:0]} < DW_U);
    // Branch offset counts words, so it is sign-extended then scaled by 4.
    assign w_offset   = PC_W'($signed(r_ir[23:16])) << 2;
    assign w_pc_plus4 = r_pc + PC_W'(4);
    assign w_target   = w_pc_plus4 + w_offset;
    assign w_unused   = &{1'b0, r_ir[15:8], r_ir[23:16]};
`ifdef CPU_MULT_EN
    assign w_mul      = w_rs1_val * w_rs2_val;
`endif

    // Instruction decode and ALU evaluated from the latched instruction word
    always_comb begin
        w_result  = {DATA_W{1'b0}};
        w_wen     = 1'b0;
        w_illegal = 1'b0;
        w_taken   = 1'b0;
        case (w_opcode)
            OP_LOADI: begin
                w_result = w_imm;
                w_wen    = 1'b1;
            end
            OP_MOV: begin
                w_result = w_rs2_val;
                w_wen    = 1'b1;
            end
            OP_ADD: begin
                w_result = w_rs1_val + w_rs2_val;
                w_wen    = 1'b1;
            end
            OP_SUB: begin
                w_result = w_rs1_val - w_rs2_val;
                w_wen    = 1'b1;
            end
            OP_AND: begin
                w_result = w_rs1_val & w_rs2_val;
                w_wen    = 1'b1;
            end
            OP_OR: begin
                w_result = w_rs1_val | w_rs2_val;
                w_wen    = 1'b1;
            end
            OP_J: begin
                w_taken = 1'b1;
            end
            OP_BEQ: begin
                w_taken = (w_rs1_val == w_rs2_val);
            end
            OP_BNE: begin
                w_taken = (w_rs1_val != w_rs2_val);
            end
            OP_SLL: begin
                if (w_shamt_ok) begin
                    w_result = w_rs1_val << r_ir[7:0];
                end else begin
                    w_result = {DATA_W{1'b0}};
                end
                w_wen = 1'b1;
            end
            OP_SRL: begin
                if (w_shamt_ok) begin
                    w_result = w_rs1_val >> r_ir[7:0];
                end else begin
                    w_result = {DATA_W{1'b0}};
                end
                w_wen = 1'b1;
            end
`ifdef CPU_MULT_EN
            OP_MUL: begin
                w_result = w_mul;
                w_wen    = 1'b1;
            end
`endif
            default: begin
                w_illegal = 1'b1;
            end
        endcase
    end

    // Next program counter selection
    always_comb begin
        w_next_pc = w_pc_plus4;
        if (w_taken) begin
            w_next_pc = w_target;
        end else begin
            w_next_pc = w_pc_plus4;
        end
    end

    // Control FSM, architectural state and registered outputs
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state   <= S_RST;
            r_ir      <= 32'd0;
            r_pc      <= {PC_W{1'b0}};
            r_next_pc <= {PC_W{1'b0}};
            r_addr    <= {PC_W{1'b0}};
            r_alu     <= {DATA_W{1'b0}};
            r_wen     <= 1'b0;
            r_req     <= 1'b0;
            r_retire  <= 1'b0;
            r_illegal <= 1'b0;
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= {DATA_W{1'b0}};
            end
        end else begin
            case (r_state)
                S_RST: begin
                    r_req   <= 1'b1;
                    r_addr  <= r_pc;
                    r_state <= S_FETCH;
                end
                S_FETCH: begin
                    if (INSTR_READY) begin
                        r_ir    <= INSTRUCTION;
                        r_req   <= 1'b0;
                        r_state <= S_EXEC;
                    end else begin
                        r_state <= S_FETCH;
                    end
                end
                S_EXEC: begin
                    r_alu     <= w_result;
                    r_wen     <= w_wen;
                    r_next_pc <= w_next_pc;
                    r_retire  <= 1'b1;
                    r_illegal <= w_illegal;
                    r_state   <= S_WB;
                end
                S_WB: begin
                    // The write lands on the edge leaving S_WB, so a reset during S_WB drops it.
                    if (r_wen) begin
                        r_regs[w_rd_idx] <= r_alu;
                    end
                    r_pc      <= r_next_pc;
                    r_addr    <= r_next_pc;
                    r_req     <= 1'b1;
                    r_retire  <= 1'b0;
                    r_illegal <= 1'b0;
                    r_wen     <= 1'b0;
                    r_state   <= S_FETCH;
                end
                default: begin
                    r_state <= S_RST;
                end
            endcase
        end
    end

    assign INSTR_REQ  = r_req;
    assign INSTR_ADDR = r_addr;
    assign PC         = r_pc;
    assign RETIRE     = r_retire;
    assign ILLEGAL    = r_illegal;

endmodule

// File: doc/cpu_mc.md
Name: cpu_mc

Overview:
Parametrised multi-cycle successor to the single-cycle lab CPU.
- Fetches 32-bit instructions over a request/ready handshake, so instruction memory may take any number of cycles.
- Executes from an internal register file and ALU.
- Adds jumps, conditional branches, shifts and illegal-opcode flagging.
- Top-level processor core; instruction memory is external.

Parameters:
DATA_W, 8, register/ALU data width (>=8)
REG_ADDR_W, 3, register index width; register count = 2**REG_ADDR_W (<=8)
PC_W, 32, program counter width

Ports:
CLK  input  1  clock, rising edge
RESET  input  1  asynchronous, active-low reset
INSTR_REQ  output  1  fetch request
INSTR_ADDR  output  PC_W  fetch address (= PC)
INSTRUCTION  input  32  instruction word, valid when INSTR_READY=1
INSTR_READY  input  1  memory has INSTRUCTION valid
RETIRE  output  1  one-cycle pulse when an instruction completes
ILLEGAL  output  1  one-cycle pulse with RETIRE for an undefined opcode
PC  output  PC_W  current program counter

Behaviour:
- Encoding: opcode [31:24], rd/offset [23:16], rs1 [15:8], rs2/imm [7:0].
  - Register indices are the low REG_ADDR_W bits of each field.
  - Immediate is imm[7:0] sign-extended to DATA_W.
- Opcodes:
  - 0x00 loadi rd=imm
  - 0x01 mov rd=rs2
  - 0x02 add rd=rs1+rs2
  - 0x03 sub rd=rs1-rs2 (two's complement)
  - 0x04 and
  - 0x05 or
  - 0x06 j
  - 0x07 beq rs1==rs2
  - 0x08 bne rs1!=rs2
  - 0x09 sll rd=rs1<<imm
  - 0x0A srl rd=rs1>>imm (logical)
  - All other opcodes: NOP with ILLEGAL pulse.
- Arithmetic wraps modulo 2**DATA_W. A shift amount (imm as unsigned 8-bit) >= DATA_W yields 0.
- Jump/branch target = PC+4+(sext([23:16])<<2), modulo 2**PC_W. Not taken: PC+4.
- States:
  - S_RST → S_FETCH: on the first CLK edge after RESET deasserts.
  - S_FETCH: INSTR_REQ=1, INSTR_ADDR=PC. On an edge with INSTR_READY=1, latch INSTRUCTION into IR and go to S_EXEC; otherwise stay. INSTR_ADDR is stable for the whole request.
  - S_EXEC: read rs1/rs2, compute ALU result and compare flag into internal registers; go to S_WB.
  - S_WB: write rd for loadi/mov/add/sub/and/or/sll/srl; update PC; RETIRE=1; go to S_FETCH.
- Latency: 3 cycles per instruction when INSTR_READY is high in the first S_FETCH cycle. Each extra S_FETCH wait cycle adds 1.
- INSTRUCTION is ignored outside S_FETCH and whenever INSTR_READY=0. INSTR_READY outside S_FETCH has no effect.
- rd==rs1 or rd==rs2: operands are read in S_EXEC and written in S_WB, so the old value is used.
- Register 0 is an ordinary writable register.
- PC wraps at 2**PC_W with no fault.
- Reset value of every output: INSTR_REQ=0, INSTR_ADDR=0, PC=0, RETIRE=0, ILLEGAL=0.
- Reset also clears all registers, IR and the state (to S_RST).
- Asserting RESET at any point, including mid-fetch or in S_WB, aborts the instruction immediately. No register write occurs for the aborted instruction.

Optional Feature:
CPU_MULT_EN
- Defined: opcode 0x0B mul, rd = low DATA_W bits of rs1*rs2 (unsigned product). Same 3-cycle timing, no ILLEGAL.
- Undefined: 0x0B is illegal (NOP, ILLEGAL pulse, PC+4).

Test Plan:
- Reset and fetch handshake: hold RESET=0 3 cycles, release, INSTR_READY=1 constant → INSTR_REQ=0 until the first edge after release, then 1 with INSTR_ADDR=0; RETIRE pulses every 3 cycles; PC sequence 0,4,8.
- Arithmetic (DATA_W=8): loadi r1,0x05; loadi r2,0x07; sub r3,r1,r2 → r3=0xFE. Then add r4,r3,r2 → r4=0x05. Then loadi r5,0x80; sll r6,r5,1 → r6=0x00. sll with imm 9 → 0x00.
- Branches: r1=r2=3, beq offset 0x02 at PC=0x10 → next INSTR_ADDR 0x1C. bne same operands → 0x14. j offset 0xFE at PC=0x20 → 0x1C.
- Memory wait: INSTR_READY low 4 cycles in S_FETCH, INSTRUCTION toggling garbage → INSTR_REQ and INSTR_ADDR stable. Only the word present on the READY edge executes; retire occurs 7 cycles after entering S_FETCH.
- Illegal/opcode 0x0B: without CPU_MULT_EN → ILLEGAL and RETIRE pulse together, registers unchanged, PC+4. With CPU_MULT_EN, r1=0x10, r2=0x11 → rd=0x10.
- Reset mid-operation: assert RESET during S_EXEC of loadi r1,0x55 → r1 stays 0, PC=0, outputs at reset values. Normal fetch from 0 resumes after release.
